// File: rtl/ram_scan_ctrl_if.sv
// User write handshake and RAM-side address/write bus of the scan controller.
// The controller connects as slave; the user/RAM side connects as master.
interface ram_scan_ctrl_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 3
);
   logic              clear;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              init_done;
   logic [ADDR_W-1:0] rdaddress;
   logic [ADDR_W-1:0] wraddress;
   logic              wren;
   logic [DATA_W-1:0] datain;
   logic [ADDR_W-1:0] rd_tag;
   logic              rd_tag_valid;

   modport master (
      output clear, wr_req, wr_addr, wr_data,
      input  wr_ready, init_done, rdaddress, wraddress, wren, datain, rd_tag, rd_tag_valid
   );

   modport slave (
      input  clear, wr_req, wr_addr, wr_data,
      output wr_ready, init_done, rdaddress, wraddress, wren, datain, rd_tag, rd_tag_valid
   );
endinterface

// File: rtl/ram_scan_ctrl.sv
// Fills a registered-address dual-port RAM with a constant, then sweeps its read address
// at a programmable rate while accepting single-word user writes.
module ram_scan_ctrl #(
   parameter int unsigned       ADDR_W     = 5,
   parameter int unsigned       DATA_W     = 3,
   parameter logic [DATA_W-1:0] INIT_VAL   = '0,
   parameter int unsigned       SCAN_DIV   = 4,
   parameter int unsigned       RD_LATENCY = 2
) (
   input logic            i_clock,
   input logic            i_reset,
   ram_scan_ctrl_if.slave io_bus
);
   localparam int unsigned       DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [ADDR_W:0]   FILL_END = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [0:0] {StFill, StScan} state_e;

   state_e                             r_state, w_state_d;
   logic [ADDR_W:0]                    r_fill_cnt, w_fill_cnt_d;
   logic [DIV_W-1:0]                   r_div, w_div_d;
   logic [ADDR_W-1:0]                  r_rdaddress, w_rdaddress_d;
   logic [ADDR_W-1:0]                  r_wraddress, w_wraddress_d;
   logic                               r_wren, w_wren_d;
   logic [DATA_W-1:0]                  r_datain, w_datain_d;
   logic                               r_init_done, w_init_done_d;
   logic [RD_LATENCY-1:0][ADDR_W-1:0]  r_tag;
   logic [RD_LATENCY-1:0]              r_tag_vld;
   logic                               w_wr_ready;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= StFill;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_fill_cnt_d  = r_fill_cnt;
      w_div_d       = r_div;
      w_rdaddress_d = r_rdaddress;
      w_wraddress_d = r_wraddress;
      w_wren_d      = 1'b0;
      w_datain_d    = r_datain;
      w_init_done_d = r_init_done;
      w_wr_ready    = (r_state == StScan) && !io_bus.clear;

      if (io_bus.clear) begin
         w_state_d     = StFill;
         w_fill_cnt_d  = '0;
         w_div_d       = '0;
         w_rdaddress_d = '0;
         w_wraddress_d = '0;
         w_init_done_d = 1'b0;
      end else begin
         unique case (r_state)
            StFill: begin
               if (r_fill_cnt == FILL_END) begin
                  w_state_d     = StScan;
                  w_init_done_d = 1'b1;
               end else begin
                  w_wren_d      = 1'b1;
                  w_wraddress_d = r_fill_cnt[ADDR_W-1:0];
                  w_datain_d    = INIT_VAL;
                  w_fill_cnt_d  = r_fill_cnt + 1'b1;
               end
            end
            StScan: begin
               if (io_bus.wr_req) begin
                  w_wren_d      = 1'b1;
                  w_wraddress_d = io_bus.wr_addr;
                  w_datain_d    = io_bus.wr_data;
               end
               // The scan free-runs; user writes never hold it back.
               if (r_div == DIV_LAST) begin
                  w_div_d       = '0;
                  w_rdaddress_d = r_rdaddress + 1'b1;
               end else begin
                  w_div_d = r_div + 1'b1;
               end
            end
            default: w_state_d = StFill;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_fill_cnt  <= '0;
         r_div       <= '0;
         r_rdaddress <= '0;
         r_wraddress <= '0;
         r_wren      <= 1'b0;
         r_datain    <= '0;
         r_init_done <= 1'b0;
         r_tag       <= '0;
         r_tag_vld   <= '0;
      end else begin
         r_fill_cnt  <= w_fill_cnt_d;
         r_div       <= w_div_d;
         r_rdaddress <= w_rdaddress_d;
         r_wraddress <= w_wraddress_d;
         r_wren      <= w_wren_d;
         r_datain    <= w_datain_d;
         r_init_done <= w_init_done_d;
         // Tag pipeline mirrors the RAM's address and output registers; clear flushes valids.
         r_tag[0]     <= r_rdaddress;
         r_tag_vld[0] <= (r_state == StScan) && !io_bus.clear;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_tag[i]     <= r_tag[i-1];
            r_tag_vld[i] <= r_tag_vld[i-1] && !io_bus.clear;
         end
      end
   end

   assign io_bus.wr_ready     = w_wr_ready;
   assign io_bus.init_done    = r_init_done;
   assign io_bus.rdaddress    = r_rdaddress;
   assign io_bus.wraddress    = r_wraddress;
   assign io_bus.wren         = r_wren;
   assign io_bus.datain       = r_datain;
   assign io_bus.rd_tag       = r_tag[RD_LATENCY-1];
   assign io_bus.rd_tag_valid = r_tag_vld[RD_LATENCY-1];
endmodule
